bus_slave_controller: RTL and testbench

- Peripheral-side consumer of the 8088 minimum-mode main bus. It latches the multiplexed address on ALE and decodes a hit on a configurable memory or I/O window.
- On a hit it converts the RD/WR strobes into a request/acknowledge transaction on a simple backend (RAM, register file or I/O device).
- It stretches the bus cycle by driving READY low until the backend completes, then returns read data onto AD.

---
 rtl/bus_slave_controller.sv | 175 +++++++++++++++++
 tb/tb_bus_slave_controller.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/bus_slave_controller.sv
// 8088 minimum-mode bus slave: ALE address latch, window decode, RD/WR to req/ack backend, READY stretching.
// Optional watchdog enabled by defining BSC_TIMEOUT_EN.
//
// state  | meaning
// IDLE   | waiting for ALE, latching address while ALE is high
// ADDR   | address latched, waiting for a strobe and deciding hit/miss
// ACCESS | backend request outstanding, READY held low
// DONE   | backend finished, driving read data until strobes release
module bus_slave_controller #(
  parameter logic [19:0] BASE_ADDR      = 20'h00000,
  parameter logic [19:0] ADDR_MASK      = 20'hF0000,
  parameter bit          IS_IO          = 1'b0,
  parameter int          WAIT_STATES    = 1,
  parameter int          TIMEOUT_CYCLES = 16
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        ale_i,
  input  logic        iom_i,
  input  logic        rd_n_i,
  input  logic        wr_n_i,
  input  logic [7:0]  ad_in_i,
  input  logic [11:0] a_i,
  output logic [7:0]  ad_out_o,
  output logic        ad_oe_o,
  output logic        ready_o,
  output logic        req_o,
  output logic        we_o,
  output logic [19:0] addr_o,
  output logic [7:0]  wdata_o,
  input  logic [7:0]  rdata_i,
  input  logic        ack_i,
  output logic        timeout_o
);

  localparam int WS_EFF  = (WAIT_STATES > 1) ? WAIT_STATES : 1;
  // One counter serves both the wait-state minimum and the watchdog, so size it for the larger.
  localparam int CNT_MAX = (WS_EFF > TIMEOUT_CYCLES) ? WS_EFF : TIMEOUT_CYCLES;
  localparam int CW      = $clog2(CNT_MAX + 2);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);
  localparam logic [CW-1:0] WS_LIM  = CW'(WS_EFF);
`ifdef BSC_TIMEOUT_EN
  localparam logic [CW-1:0] TO_LIM  = CW'(TIMEOUT_CYCLES);
`endif

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ADDR   = 2'd1,
    S_ACCESS = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  state_t        state_q;
  logic          cap_q;
  logic          iom_q;
  logic [19:0]   addr_q;
  logic          we_q;
  logic [7:0]    wdata_q;
  logic          req_q;
  logic          ready_q;
  logic          ad_oe_q;
  logic [7:0]    rdata_q;
  logic          ack_seen_q;
  logic [CW-1:0] cnt_q;
  logic          hit;
  logic          ack_any;

  assign hit     = ((addr_q & ADDR_MASK) == (BASE_ADDR & ADDR_MASK)) && (iom_q == IS_IO);
  assign ack_any = ack_seen_q || ack_i;

`ifdef BSC_TIMEOUT_EN
  logic timeout_q;
  assign timeout_o = timeout_q;
`else
  assign timeout_o = 1'b0;
`endif

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q    <= S_IDLE;
      cap_q      <= 1'b0;
      iom_q      <= 1'b0;
      addr_q     <= 20'h00000;
      we_q       <= 1'b0;
      wdata_q    <= 8'h00;
      req_q      <= 1'b0;
      ready_q    <= 1'b1;
      ad_oe_q    <= 1'b0;
      rdata_q    <= 8'h00;
      ack_seen_q <= 1'b0;
      cnt_q      <= '0;
`ifdef BSC_TIMEOUT_EN
      timeout_q  <= 1'b0;
`endif
    end else begin
`ifdef BSC_TIMEOUT_EN
      timeout_q <= 1'b0;
`endif
      case (state_q)
        S_IDLE: begin
          if (ale_i) begin
            addr_q <= {a_i, ad_in_i};
            iom_q  <= iom_i;
            cap_q  <= 1'b1;
          end else if (cap_q) begin
            cap_q   <= 1'b0;
            state_q <= S_ADDR;
          end
        end
        S_ADDR: begin
          if (ale_i) begin
            addr_q <= {a_i, ad_in_i};
            iom_q  <= iom_i;
          end else if (!hit || (!rd_n_i && !wr_n_i)) begin
            state_q <= S_IDLE;
          end else if (!rd_n_i || !wr_n_i) begin
            state_q    <= S_ACCESS;
            req_q      <= 1'b1;
            we_q       <= ~wr_n_i;
            if (!wr_n_i) wdata_q <= ad_in_i;
            ready_q    <= 1'b0;
            cnt_q      <= CNT_ONE;
            ack_seen_q <= 1'b0;
          end
        end
        S_ACCESS: begin
          if (cnt_q != '1) cnt_q <= cnt_q + CNT_ONE;
          if (ack_i) begin
            req_q      <= 1'b0;
            ack_seen_q <= 1'b1;
            rdata_q    <= rdata_i;
          end
          if (ack_any && (cnt_q >= WS_LIM)) begin
            state_q <= S_DONE;
            ready_q <= 1'b1;
            ad_oe_q <= ~we_q & ~rd_n_i;
          end
`ifdef BSC_TIMEOUT_EN
          else if (!ack_any && (cnt_q >= TO_LIM)) begin
            state_q   <= S_DONE;
            req_q     <= 1'b0;
            ready_q   <= 1'b1;
            rdata_q   <= 8'hFF;
            timeout_q <= 1'b1;
            ad_oe_q   <= ~we_q & ~rd_n_i;
          end
`endif
        end
        S_DONE: begin
          if (ale_i) begin
            addr_q  <= {a_i, ad_in_i};
            iom_q   <= iom_i;
            ad_oe_q <= 1'b0;
            state_q <= S_ADDR;
          end else if (rd_n_i && wr_n_i) begin
            ad_oe_q <= 1'b0;
            state_q <= S_IDLE;
          end else begin
            ad_oe_q <= ~we_q & ~rd_n_i;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign ad_out_o = rdata_q;
  assign ad_oe_o  = ad_oe_q;
  assign ready_o  = ready_q;
  assign req_o    = req_q;
  assign we_o     = we_q;
  assign addr_o   = addr_q;
  assign wdata_o  = wdata_q;

endmodule

// File: tb/tb_bus_slave_controller.sv
// Bench for bus_slave_controller: two instances (WAIT_STATES 1 and 4) on one bus, each with its own backend.
module tb_bus_slave_controller;

  localparam logic [19:0] BASE = 20'h00000;
  localparam logic [19:0] MASK = 20'hF0000;
  localparam int WS [2] = '{1, 4};

  typedef struct {
    logic [19:0] adr;
    logic        io;
    int          kind;      // 0 read, 1 write, 2 both strobes low
    logic [7:0]  wd;
    logic [7:0]  rd;
    int          lat_a;
    int          lat_b;
    bit          exp_req;
    int          exp_low_a;
    int          exp_low_b;
  } vec_t;

  logic        clk;
  logic        rst_n;
  logic        ale, iom, rd_n, wr_n;
  logic [7:0]  ad_in;
  logic [11:0] a_in;
  logic [7:0]  rdata;
  logic        late_ack;

  logic [7:0]  ad_out_w [2];
  logic [19:0] addr_w   [2];
  logic [7:0]  wdata_w  [2];
  logic [1:0]  ad_oe_w, ready_w, req_w, we_w, timeout_w, ack_w;

  int          lat [2];
  logic [1:0]  en;
  int          k [2];

  int vectors = 0;
  int miscompares = 0;
  string cur_tag = "reset";

  int         low_cnt [2];
  int         to_cnt  [2];
  bit         req_seen[2];
  bit         oe_seen [2];
  logic [7:0] ad_last [2];

  bus_slave_controller #(.BASE_ADDR(BASE), .ADDR_MASK(MASK), .IS_IO(1'b0),
                         .WAIT_STATES(1), .TIMEOUT_CYCLES(16)) dut_a (
    .clk_i(clk), .rst_n_i(rst_n), .ale_i(ale), .iom_i(iom), .rd_n_i(rd_n), .wr_n_i(wr_n),
    .ad_in_i(ad_in), .a_i(a_in), .ad_out_o(ad_out_w[0]), .ad_oe_o(ad_oe_w[0]),
    .ready_o(ready_w[0]), .req_o(req_w[0]), .we_o(we_w[0]), .addr_o(addr_w[0]),
    .wdata_o(wdata_w[0]), .rdata_i(rdata), .ack_i(ack_w[0]), .timeout_o(timeout_w[0]));

  bus_slave_controller #(.BASE_ADDR(BASE), .ADDR_MASK(MASK), .IS_IO(1'b0),
                         .WAIT_STATES(4), .TIMEOUT_CYCLES(16)) dut_b (
    .clk_i(clk), .rst_n_i(rst_n), .ale_i(ale), .iom_i(iom), .rd_n_i(rd_n), .wr_n_i(wr_n),
    .ad_in_i(ad_in), .a_i(a_in), .ad_out_o(ad_out_w[1]), .ad_oe_o(ad_oe_w[1]),
    .ready_o(ready_w[1]), .req_o(req_w[1]), .we_o(we_w[1]), .addr_o(addr_w[1]),
    .wdata_o(wdata_w[1]), .rdata_i(rdata), .ack_i(ack_w[1]), .timeout_o(timeout_w[1]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Backend: ack is seen by the DUT lat+1 edges after the edge that raised req.
  always @(posedge clk)
    for (int i = 0; i < 2; i++) k[i] <= req_w[i] ? k[i] + 1 : 0;

  always_comb begin
    ack_w = '0;
    for (int i = 0; i < 2; i++)
      ack_w[i] = (req_w[i] && en[i] && (k[i] == lat[i])) || late_ack;
  end

  task automatic chk(input string name, input int inst, input longint act, input longint exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s/%s dut%0d: got %0h expected %0h", cur_tag, name, inst, act, exp);
    end
  endtask

  task automatic sample();
    for (int i = 0; i < 2; i++) begin
      if (!ready_w[i]) low_cnt[i]++;
      if (req_w[i]) req_seen[i] = 1'b1;
      if (timeout_w[i]) to_cnt[i]++;
      if (ad_oe_w[i]) begin
        oe_seen[i] = 1'b1;
        ad_last[i] = ad_out_w[i];
      end
    end
  endtask

  task automatic bus_cycle(input logic [19:0] adr, input logic io, input int kind,
                           input logic [7:0] wd, input int hold, input int late_at);
    for (int i = 0; i < 2; i++) begin
      low_cnt[i] = 0; to_cnt[i] = 0; req_seen[i] = 1'b0; oe_seen[i] = 1'b0; ad_last[i] = 8'h00;
    end
    @(negedge clk);
    ale = 1'b1; a_in = adr[19:8]; ad_in = adr[7:0]; iom = io;
    @(negedge clk);
    ale = 1'b0; ad_in = (kind == 1) ? wd : 8'h00;
    sample();
    @(negedge clk);
    sample();
    rd_n = (kind == 1);
    wr_n = (kind == 0);
    for (int c = 0; c < hold; c++) begin
      @(negedge clk);
      late_ack = (c == late_at);
      sample();
    end
    late_ack = 1'b0; rd_n = 1'b1; wr_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      sample();
    end
  endtask

  task automatic do_vec(input vec_t v);
    int exp_low [2];
    exp_low[0] = v.exp_low_a;
    exp_low[1] = v.exp_low_b;
    lat[0] = v.lat_a; lat[1] = v.lat_b; en = 2'b11; rdata = v.rd;
    bus_cycle(v.adr, v.io, v.kind, v.wd, 12, -1);
    for (int i = 0; i < 2; i++) begin
      chk("ready_low_cycles", i, low_cnt[i], exp_low[i]);
      chk("req_seen", i, req_seen[i], v.exp_req);
      chk("addr", i, addr_w[i], v.adr);
      chk("oe_seen", i, oe_seen[i], v.exp_req && (v.kind == 0));
      if (v.exp_req && v.kind == 0) chk("read_data", i, ad_last[i], v.rd);
      if (v.exp_req) chk("we", i, we_w[i], v.kind == 1);
      if (v.exp_req && v.kind == 1) chk("wdata", i, wdata_w[i], v.wd);
      chk("oe_after", i, ad_oe_w[i], 0);
      chk("ready_after", i, ready_w[i], 1);
      chk("timeout_pulses", i, to_cnt[i], 0);
    end
  endtask

  // Reference: a hit with one strobe costs max(latency+1, max(WAIT_STATES,1)) READY-low cycles.
  function automatic vec_t model(input vec_t v);
    vec_t r = v;
    bit hit = ((v.adr & MASK) == (BASE & MASK)) && (v.io == 1'b0);
    int la = v.lat_a + 1;
    int lb = v.lat_b + 1;
    r.exp_req   = hit && (v.kind != 2);
    r.exp_low_a = r.exp_req ? ((la > WS[0]) ? la : WS[0]) : 0;
    r.exp_low_b = r.exp_req ? ((lb > WS[1]) ? lb : WS[1]) : 0;
    return r;
  endfunction

  vec_t tbl [8];

  initial begin
    tbl[0] = '{20'h01234, 1'b0, 0, 8'h00, 8'h5A, 2, 2, 1'b1, 3, 4};
    tbl[1] = '{20'h000FF, 1'b0, 1, 8'hC3, 8'h00, 0, 0, 1'b1, 1, 4};
    tbl[2] = '{20'h10000, 1'b0, 0, 8'h00, 8'h11, 0, 0, 1'b0, 0, 0};
    tbl[3] = '{20'h01234, 1'b1, 0, 8'h00, 8'h22, 0, 0, 1'b0, 0, 0};
    tbl[4] = '{20'h00010, 1'b0, 2, 8'h44, 8'h33, 0, 0, 1'b0, 0, 0};
    tbl[5] = '{20'h0ABCD, 1'b0, 0, 8'h00, 8'h3C, 5, 1, 1'b1, 6, 4};
    tbl[6] = '{20'h0FFFF, 1'b0, 1, 8'h81, 8'h00, 4, 3, 1'b1, 5, 4};
    tbl[7] = '{20'h0F000, 1'b0, 0, 8'h00, 8'hE7, 0, 6, 1'b1, 1, 7};

    rst_n = 1'b0; ale = 1'b0; iom = 1'b0; rd_n = 1'b1; wr_n = 1'b1;
    ad_in = 8'h00; a_in = 12'h000; rdata = 8'h00; late_ack = 1'b0;
    en = 2'b00; lat[0] = 0; lat[1] = 0;

    repeat (3) @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      chk("ready", i, ready_w[i], 1);
      chk("ad_oe", i, ad_oe_w[i], 0);
      chk("ad_out", i, ad_out_w[i], 0);
      chk("req", i, req_w[i], 0);
      chk("we", i, we_w[i], 0);
      chk("addr", i, addr_w[i], 0);
      chk("wdata", i, wdata_w[i], 0);
      chk("timeout", i, timeout_w[i], 0);
    end
    rst_n = 1'b1;

    for (int n = 0; n < 8; n++) begin
      cur_tag = $sformatf("table%0d", n);
      do_vec(tbl[n]);
    end

    // Reset while a request is outstanding, then a clean access.
    cur_tag = "reset_mid";
    en = 2'b00;
    @(negedge clk);
    ale = 1'b1; a_in = 12'h001; ad_in = 8'h00; iom = 1'b0;
    @(negedge clk);
    ale = 1'b0;
    @(negedge clk);
    rd_n = 1'b0;
    repeat (4) @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      chk("ready_before", i, ready_w[i], 0);
      chk("req_before", i, req_w[i], 1);
    end
    #2 rst_n = 1'b0;
    #1;
    for (int i = 0; i < 2; i++) begin
      chk("ready_async", i, ready_w[i], 1);
      chk("req_async", i, req_w[i], 0);
      chk("ad_oe_async", i, ad_oe_w[i], 0);
    end
    rd_n = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    cur_tag = "after_reset";
    do_vec(tbl[0]);

`ifdef BSC_TIMEOUT_EN
    cur_tag = "timeout";
    en = 2'b00; rdata = 8'h77;
    bus_cycle(20'h00100, 1'b0, 0, 8'h00, 22, 19);
    for (int i = 0; i < 2; i++) begin
      chk("ready_low_cycles", i, low_cnt[i], 16);
      chk("timeout_pulses", i, to_cnt[i], 1);
      chk("oe_seen", i, oe_seen[i], 1);
      chk("read_data", i, ad_last[i], 8'hFF);
      chk("oe_after", i, ad_oe_w[i], 0);
      chk("req_after", i, req_w[i], 0);
    end
`endif

    for (int n = 0; n < 30; n++) begin
      vec_t v;
      int r;
      r = $urandom_range(0, 7);
      v.adr[19:16] = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(1, 15)) : 4'h0;
      v.adr[15:0]  = 16'($urandom);
      v.io    = ($urandom_range(0, 4) == 0);
      v.kind  = (r == 0) ? 2 : (r % 2);
      v.wd    = 8'($urandom);
      v.rd    = 8'($urandom);
      v.lat_a = $urandom_range(0, 6);
      v.lat_b = $urandom_range(0, 6);
      v = model(v);
      cur_tag = $sformatf("rand%0d", n);
      do_vec(v);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
